memory_port_sequencer: RTL and testbench
========================================

// Module: memory_port_sequencer
// PURPOSE
//  Initiator side of the time-multiplexed dual-port memory block. Generates the
//  write_clock slot phase, presents port A (fetch) and port B (load/store) addresses
//  in their slots, and captures portA_out/portB_out. Exposes valid/ready channels to
//  the core. Sits between core fetch/load-store logic and one memory block.
// PARAMETERS
//  data_width     16   width of data words
//  address_width  10   width of word addresses
// PORTS
//  clock             in   1    single system clock (posedge logic; slot flop on negedge)
//  reset             in   1    asynchronous, active-high
//  req_valid         in   1    load/store request (port B channel)
//  req_ready         out  1    request accepted on posedge when valid&&ready
//  req_write         in   1    1=store, 0=load
//  req_address       in   AW   port B word address
//  req_data          in   DW   store data
//  rsp_valid         out  1    one-cycle pulse: port B result
//  rsp_data          out  DW   loaded word (store: prior contents)
//  fetch_valid       in   1    fetch request (port A channel)
//  fetch_ready       out  1    fetch accepted on posedge when valid&&ready
//  fetch_address     in   AW   port A word address
//  fetch_rsp_valid   out  1    one-cycle pulse: fetch result
//  fetch_data        out  DW   fetched word
//  mem_write_clock   out  1    slot phase to memory (1=B slot, 0=A slot)
//  mem_write_enable  out  1    write strobe to memory
//  mem_portA_address out  AW
//  mem_portB_address out  AW
//  mem_data_in       out  DW
//  mem_portA_out     in   DW
//  mem_portB_out     in   DW
// BEHAVIOUR
//  - Reset (async): mem_write_clock=0, mem_write_enable=0, all addresses/data=0,
//    rsp_valid=fetch_rsp_valid=0, rsp_data=fetch_data=0, both FSMs IDLE.
//  - mem_write_clock toggles on every negedge clock after reset deasserts; posedge
//    logic always sees it stable. "B edge" = posedge with it 1; "A edge" = posedge with it 0.
//  - Port B FSM: IDLE -> ARMED -> WAIT.
//    req_ready = ~mem_write_clock && (IDLE || WAIT). On accept (A edge): latch
//    portB_address, data_in; mem_write_enable<=req_write; ->ARMED.
//    ARMED, B edge: memory performs access; mem_write_enable<=0; ->WAIT.
//    WAIT, A edge: rsp_data<=mem_portB_out, rsp_valid=1 next cycle; accept new req
//    (->ARMED) or ->IDLE. Latency: accept edge N -> rsp_valid after edge N+2.
//    Throughput: one request per 2 cycles.
//  - mem_write_enable is high only in ARMED, never across an A edge.
//  - Store response: rsp_data = word contents before the write (read-before-write).
//  - Port A FSM: IDLE -> ARMED -> WAIT, mirrored one slot later.
//    fetch_ready = mem_write_clock && (IDLE || WAIT). Accept on B edge: latch
//    portA_address. A edge: memory reads. Next B edge: fetch_data<=mem_portA_out,
//    fetch_rsp_valid pulses. Latency 2 edges.
//  - Channels independent; simultaneous activity never conflicts (disjoint slots).
//  - Store at B edge T followed by fetch of same address at A edge T+1 returns new data.
//  - Inputs held while valid&&~ready; no request is dropped or duplicated.
//  - Reset mid-operation: write_enable drops immediately; in-flight responses are
//    discarded (no rsp pulse after reset); slot restarts at A phase.
// STRUCTURE
//  - Shared include memory_defs.vh: FSM state encodings (IDLE/ARMED/WAIT), slot
//    constants SLOT_A=0/SLOT_B=1.
//  - One sub-module: slot_phase_gen (negedge toggle flop, async reset) driving
//    mem_write_clock. Both channel FSMs inline.
// TESTING (bench instantiates memory_block beside the DUT)
//  - Reset release: first negedge sets mem_write_clock=1; all outputs 0 until then.
//  - Store 0xBEEF @0x012, then load 0x012 -> rsp_data 0xBEEF; store rsp_data = old 0x0000.
//  - Fetch 0x3FF preloaded 0x1234 -> fetch_rsp_valid with 0x1234, 2 edges after accept.
//  - Back-to-back loads 0x001,0x002 with fetch every slot -> 1 rsp per 2 cycles, fetch data correct.
//  - Store 0xA5A5 @0x040 at B edge, fetch 0x040 next A edge -> fetch_data 0xA5A5.
//  - Assert reset while ARMED with store -> no write to memory, no rsp_valid pulse.

Source files
------------

// File: rtl/memory_port_sequencer_pkg.sv
// memory_port_sequencer_pkg: shared widths, slot phase constants and channel FSM states
package memory_port_sequencer_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDRESS_WIDTH = 10;
  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_WAIT} state_t;
endpackage

// File: rtl/memory_port_sequencer_if.sv
// memory_port_sequencer_if: core valid/ready channels plus the slotted memory-block bus
interface memory_port_sequencer_if #(
  parameter int data_width = memory_port_sequencer_pkg::DATA_WIDTH,
  parameter int address_width = memory_port_sequencer_pkg::ADDRESS_WIDTH
);
  logic req_valid, req_ready, req_write, rsp_valid;
  logic fetch_valid, fetch_ready, fetch_rsp_valid;
  logic mem_write_clock, mem_write_enable;
  logic [address_width-1:0] req_address, fetch_address, mem_portA_address, mem_portB_address;
  logic [data_width-1:0] req_data, rsp_data, fetch_data, mem_data_in, mem_portA_out, mem_portB_out;
  modport slave (
    input req_valid, req_write, req_address, req_data, fetch_valid, fetch_address,
          mem_portA_out, mem_portB_out,
    output req_ready, rsp_valid, rsp_data, fetch_ready, fetch_rsp_valid, fetch_data,
           mem_write_clock, mem_write_enable, mem_portA_address, mem_portB_address, mem_data_in
  );
  modport master (
    output req_valid, req_write, req_address, req_data, fetch_valid, fetch_address,
           mem_portA_out, mem_portB_out,
    input req_ready, rsp_valid, rsp_data, fetch_ready, fetch_rsp_valid, fetch_data,
          mem_write_clock, mem_write_enable, mem_portA_address, mem_portB_address, mem_data_in
  );
endinterface

// File: rtl/memory_port_sequencer_slot_phase_gen.sv
// memory_port_sequencer_slot_phase_gen: negedge toggle flop producing the A/B slot phase
module memory_port_sequencer_slot_phase_gen
  import memory_port_sequencer_pkg::*;
(
  input  logic clock,
  input  logic reset,
  output logic phase
);
  always_ff @(negedge clock or posedge reset)
    if (reset) phase <= SLOT_A;
    else phase <= ~phase;
endmodule

// File: rtl/memory_port_sequencer.sv
// memory_port_sequencer: slots port B (load/store) and port A (fetch) onto a time-multiplexed memory block
module memory_port_sequencer
  import memory_port_sequencer_pkg::*;
(
  input logic clock,
  input logic reset,
  memory_port_sequencer_if.slave bus
);
  state_t b_state, b_next, a_state, a_next;
  logic slot, b_accept, a_accept, b_done, a_done;
  memory_port_sequencer_slot_phase_gen u_slot (.clock(clock), .reset(reset), .phase(slot));
  assign bus.mem_write_clock = slot;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      b_state <= ST_IDLE;
      a_state <= ST_IDLE;
    end else begin
      b_state <= b_next;
      a_state <= a_next;
    end
  // ARMED is always entered one slot before its access edge, so it lasts exactly one cycle
  always_comb begin
    b_next = b_state == ST_ARMED ? (slot == SLOT_B ? ST_WAIT : ST_ARMED)
           : b_accept ? ST_ARMED
           : (b_state == ST_WAIT && slot == SLOT_A) ? ST_IDLE : b_state;
    a_next = a_state == ST_ARMED ? (slot == SLOT_A ? ST_WAIT : ST_ARMED)
           : a_accept ? ST_ARMED
           : (a_state == ST_WAIT && slot == SLOT_B) ? ST_IDLE : a_state;
  end
  always_comb begin
    bus.req_ready = slot == SLOT_A && b_state != ST_ARMED;
    bus.fetch_ready = slot == SLOT_B && a_state != ST_ARMED;
    b_accept = bus.req_valid && bus.req_ready;
    a_accept = bus.fetch_valid && bus.fetch_ready;
    b_done = b_state == ST_WAIT && slot == SLOT_A;
    a_done = a_state == ST_WAIT && slot == SLOT_B;
  end
  // write strobe spans only accept (A edge) to access (B edge)
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus.mem_write_enable <= 1'b0;
      bus.mem_portA_address <= '0;
      bus.mem_portB_address <= '0;
      bus.mem_data_in <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.fetch_rsp_valid <= 1'b0;
      bus.fetch_data <= '0;
    end else begin
      bus.mem_write_enable <= b_accept && bus.req_write;
      if (b_accept) begin
        bus.mem_portB_address <= bus.req_address;
        bus.mem_data_in <= bus.req_data;
      end
      if (a_accept) bus.mem_portA_address <= bus.fetch_address;
      bus.rsp_valid <= b_done;
      if (b_done) bus.rsp_data <= bus.mem_portB_out;
      bus.fetch_rsp_valid <= a_done;
      if (a_done) bus.fetch_data <= bus.mem_portA_out;
    end
endmodule

// File: tb/tb_memory_port_sequencer.sv
// tb_memory_port_sequencer: directed vectors against a behavioural slotted memory block
module tb_memory_port_sequencer;
  typedef struct packed {
    logic fetch;
    logic write;
    logic [9:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  int edge_n = 0;
  int checks = 0;
  int passed = 0;
  logic [15:0] mem [1024];
  vec_t vecs [8];
  int acc, at, acc_t, fa_t, at_t, acc1, acc2, r1, r2, npulse;
  int fa [4];
  int fr [4];
  logic [15:0] d, d1, d2, d_t;
  logic [15:0] fd [4];
  logic [9:0] faddr [4];
  logic [15:0] fexp [4];

  memory_port_sequencer_if bus ();
  memory_port_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  // memory block: port B access on B edges (read-before-write), port A read on A edges
  always @(posedge clock)
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[10'h3FF] <= 16'h1234;
      mem[10'h001] <= 16'h1111;
      mem[10'h002] <= 16'h2222;
      bus.mem_portA_out <= '0;
      bus.mem_portB_out <= '0;
    end else if (bus.mem_write_clock) begin
      bus.mem_portB_out <= mem[bus.mem_portB_address];
      if (bus.mem_write_enable) mem[bus.mem_portB_address] <= bus.mem_data_in;
    end else bus.mem_portA_out <= mem[bus.mem_portA_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic b_issue(input logic w, input logic [9:0] a, input logic [15:0] dat, output int acc_e);
    logic ok;
    int tries;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_address = a;
    bus.req_data = dat;
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 20) begin
      @(negedge clock); #1;
      ok = bus.req_ready;
      @(posedge clock); #1;
      tries++;
    end
    acc_e = ok ? edge_n : -1;
    check("req_accept", {31'b0, ok}, 1);
  endtask

  task automatic a_issue(input logic [9:0] a, output int acc_e);
    logic ok;
    int tries;
    bus.fetch_valid = 1'b1;
    bus.fetch_address = a;
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 20) begin
      @(negedge clock); #1;
      ok = bus.fetch_ready;
      @(posedge clock); #1;
      tries++;
    end
    acc_e = ok ? edge_n : -1;
    check("fetch_accept", {31'b0, ok}, 1);
  endtask

  task automatic b_wait(output logic [15:0] dat, output int at_e);
    at_e = -1;
    dat = '0;
    for (int i = 0; i < 12 && at_e < 0; i++) begin
      @(posedge clock); #1;
      if (bus.rsp_valid) begin
        dat = bus.rsp_data;
        at_e = edge_n;
      end
    end
    check("rsp_seen", {31'b0, at_e >= 0}, 1);
  endtask

  task automatic a_wait(output logic [15:0] dat, output int at_e);
    at_e = -1;
    dat = '0;
    for (int i = 0; i < 12 && at_e < 0; i++) begin
      @(posedge clock); #1;
      if (bus.fetch_rsp_valid) begin
        dat = bus.fetch_data;
        at_e = edge_n;
      end
    end
    check("fetch_rsp_seen", {31'b0, at_e >= 0}, 1);
  endtask

  event b_acc_ev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 10'h012, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 10'h012, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 10'h3FF, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 10'h012, 16'hCAFE, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 10'h012, 16'h0000, 16'hCAFE};
    vecs[5] = '{1'b0, 1'b0, 10'h3FF, 16'h0000, 16'h1234};
    vecs[6] = '{1'b0, 1'b1, 10'h000, 16'h5A5A, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 10'h000, 16'h0000, 16'h5A5A};
    faddr = '{10'h3FF, 10'h001, 10'h002, 10'h040};
    fexp = '{16'h1234, 16'h1111, 16'h2222, 16'hA5A5};
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_address = '0;
    bus.req_data = '0;
    bus.fetch_valid = 1'b0;
    bus.fetch_address = '0;

    @(posedge clock); #1;
    preload = 1'b0;
    @(posedge clock); #1;
    check("rst_write_clock", bus.mem_write_clock, 0);
    check("rst_write_enable", bus.mem_write_enable, 0);
    check("rst_portA_address", bus.mem_portA_address, 0);
    check("rst_portB_address", bus.mem_portB_address, 0);
    check("rst_data_in", bus.mem_data_in, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_fetch_rsp_valid", bus.fetch_rsp_valid, 0);
    check("rst_fetch_data", bus.fetch_data, 0);
    reset = 1'b0;
    check("release_write_clock", bus.mem_write_clock, 0);
    @(negedge clock); #1;
    check("first_negedge_write_clock", bus.mem_write_clock, 1);
    check("b_slot_req_ready", bus.req_ready, 0);
    check("b_slot_fetch_ready", bus.fetch_ready, 1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].fetch) begin
        a_issue(vecs[i].addr, acc);
        bus.fetch_valid = 1'b0;
        check($sformatf("v%0d_accept_slot", i), bus.mem_write_clock, 1);
        a_wait(d, at);
        check($sformatf("v%0d_fetch_data", i), d, vecs[i].exp);
        check($sformatf("v%0d_latency", i), at - acc, 2);
        @(posedge clock); #1;
        check($sformatf("v%0d_pulse_end", i), bus.fetch_rsp_valid, 0);
      end else begin
        b_issue(vecs[i].write, vecs[i].addr, vecs[i].data, acc);
        bus.req_valid = 1'b0;
        check($sformatf("v%0d_accept_slot", i), bus.mem_write_clock, 0);
        check($sformatf("v%0d_write_enable", i), bus.mem_write_enable, vecs[i].write);
        b_wait(d, at);
        check($sformatf("v%0d_rsp_data", i), d, vecs[i].exp);
        check($sformatf("v%0d_latency", i), at - acc, 2);
        @(posedge clock); #1;
        check($sformatf("v%0d_pulse_end", i), bus.rsp_valid, 0);
      end
    end

    fork
      begin
        b_issue(1'b1, 10'h040, 16'hA5A5, acc_t);
        bus.req_valid = 1'b0;
        -> b_acc_ev;
        b_wait(d_t, at_t);
        check("st40_old_data", d_t, 16'h0000);
      end
      begin
        @(b_acc_ev);
        a_issue(10'h040, fa_t);
        bus.fetch_valid = 1'b0;
        check("f40_next_slot", fa_t - acc_t, 1);
        a_wait(d, at);
        check("f40_new_data", d, 16'hA5A5);
      end
    join
    repeat (2) @(posedge clock);
    #1;

    fork
      begin
        b_issue(1'b0, 10'h001, 16'h0000, acc1);
        b_issue(1'b0, 10'h002, 16'h0000, acc2);
        bus.req_valid = 1'b0;
      end
      begin
        b_wait(d1, r1);
        b_wait(d2, r2);
      end
      begin
        for (int i = 0; i < 4; i++) a_issue(faddr[i], fa[i]);
        bus.fetch_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) a_wait(fd[i], fr[i]);
      end
    join
    check("b2b_load1", d1, 16'h1111);
    check("b2b_load2", d2, 16'h2222);
    check("b2b_accept_gap", acc2 - acc1, 2);
    check("b2b_latency", r1 - acc1, 2);
    check("b2b_rsp_gap", r2 - r1, 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_fetch%0d_data", i), fd[i], fexp[i]);
      check($sformatf("b2b_fetch%0d_latency", i), fr[i] - fa[i], 2);
      if (i > 0) check($sformatf("b2b_fetch%0d_gap", i), fa[i] - fa[i-1], 2);
    end
    repeat (2) @(posedge clock);
    #1;

    b_issue(1'b1, 10'h050, 16'h7777, acc);
    bus.req_valid = 1'b0;
    @(negedge clock); #1;
    check("mid_we_armed", bus.mem_write_enable, 1);
    reset = 1'b1;
    #1;
    check("mid_we_drop", bus.mem_write_enable, 0);
    check("mid_slot_restart", bus.mem_write_clock, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    npulse = 0;
    repeat (8) begin
      @(posedge clock); #1;
      npulse += int'(bus.rsp_valid) + int'(bus.fetch_rsp_valid);
    end
    check("mid_no_rsp_pulse", npulse, 0);
    check("mid_no_write", mem[10'h050], 16'h0000);
    b_issue(1'b0, 10'h050, 16'h0000, acc);
    bus.req_valid = 1'b0;
    b_wait(d, at);
    check("post_reset_load", d, 16'h0000);
    check("post_reset_latency", at - acc, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
